fir_tdm_engine: RTL and testbench

Parametrised, single-clock, time-multiplexed FIR engine. It is the successor to the fixed 64-tap, 16-bit, dual-clock filter ALU. One shared multiply-accumulate unit (MAC) is swept over TAPS coefficients per input sample. Width, depth, output scaling and saturation are generic. Valid/ready handshakes replace the fixed sample clock. The block sits between the sample source and the output sink, and coefficients are loaded over a serial port.

---
 rtl/fir_tdm_engine.sv | 176 +++++++++++++++++
 tb/tb_fir_tdm_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_engine
//  Description : Time-multiplexed FIR filter. A single multiply-accumulate
//                unit sweeps TAPS coefficients per accepted sample. Samples
//                arrive over a valid/ready handshake, coefficients are
//                streamed in serially, and the output is shifted, then
//                saturated or wrapped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tdm_engine #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 64,
    parameter int OUT_SHIFT = 15,
    parameter int SAT_EN    = 1,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     ALU_restn,
    input  logic signed [COEF_W-1:0] b,
    input  logic                     b_valid,
    input  logic                     b_first,
    output logic                     coef_ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_valid,
    output logic                     overrun
);

    localparam int c_aw = $clog2(TAPS);
    localparam int c_iw = $clog2(TAPS + 1);
    localparam int c_pw = DATA_W + COEF_W;
    localparam logic [c_aw-1:0] c_last = c_aw'(TAPS - 1);
    localparam logic signed [DATA_W-1:0] c_y_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_y_min = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_IDLE = 2'd1,
        S_MAC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                    state_q;
    logic [c_iw-1:0]           idx_q;
    logic [c_aw-1:0]           wp_q;
    logic [c_aw-1:0]           k_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  delay_q [TAPS];
    logic signed [COEF_W-1:0]  coef_q  [TAPS];
    logic                      coef_ready_q;
    logic                      overrun_q;
    logic signed [DATA_W-1:0]  y_q;
    logic                      y_valid_q;

    logic                      load_ok_d;
    logic                      first_beat_d;
    logic                      next_beat_d;
    logic                      coef_we_d;
    logic [c_aw-1:0]           coef_wa_d;
    logic [c_aw:0]             wrap_sum_d;
    logic [c_aw-1:0]           tap_d;
    logic signed [c_pw-1:0]    prod_d;
    logic signed [ACC_W-1:0]   prod_ext_d;
    logic signed [ACC_W-1:0]   shifted_d;
    logic [ACC_W-DATA_W:0]     hi_d;
    logic signed [DATA_W-1:0]  y_d;

    // A restart beat in IDLE steals the cycle from any sample offered with it
    assign x_ready    = (state_q == S_IDLE) && coef_ready_q && !(b_valid && b_first);
    assign coef_ready = coef_ready_q;
    assign y          = y_q;
    assign y_valid    = y_valid_q;
    assign overrun    = overrun_q;

    // Coefficient beat decode: loads are accepted only outside a sweep
    always_comb begin
        load_ok_d    = (state_q == S_LOAD) || (state_q == S_IDLE);
        first_beat_d = load_ok_d && b_valid && b_first;
        next_beat_d  = load_ok_d && b_valid && !b_first && (idx_q < c_iw'(TAPS));
        coef_we_d    = first_beat_d || next_beat_d;
        coef_wa_d    = first_beat_d ? '0 : idx_q[c_aw-1:0];
    end

    // Tap address (wp - k) mod TAPS and the sign-extended MAC product
    always_comb begin
        wrap_sum_d = {1'b0, wp_q} + (c_aw + 1)'(TAPS) - {1'b0, k_q};
        if (wp_q >= k_q) begin
            tap_d = wp_q - k_q;
        end else begin
            tap_d = wrap_sum_d[c_aw-1:0];
        end
        prod_d     = coef_q[k_q] * delay_q[tap_d];
        prod_ext_d = {{(ACC_W-c_pw){prod_d[c_pw-1]}}, prod_d};
    end

    // Output scaling: arithmetic shift, then clamp or keep the low bits
    always_comb begin
        shifted_d = acc_q >>> OUT_SHIFT;
        hi_d      = shifted_d[ACC_W-1:DATA_W-1];
        y_d       = shifted_d[DATA_W-1:0];
        if ((SAT_EN != 0) && !((&hi_d) || !(|hi_d))) begin
            y_d = shifted_d[ACC_W-1] ? c_y_min : c_y_max;
        end
    end

    // Coefficient memory survives reset; coef_ready marks it valid
    always_ff @(posedge clk) begin
        if (ALU_restn && coef_we_d) begin
            coef_q[coef_wa_d] <= b;
        end
    end

    // Control FSM, delay line, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (!ALU_restn) begin
            state_q      <= S_LOAD;
            idx_q        <= '0;
            wp_q         <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            coef_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            if (x_valid && !x_ready) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                S_LOAD, S_IDLE: begin
                    if (first_beat_d) begin
                        idx_q        <= c_iw'(1);
                        coef_ready_q <= 1'b0;
                        state_q      <= S_LOAD;
                    end else if (next_beat_d) begin
                        idx_q <= idx_q + c_iw'(1);
                        if (idx_q == c_iw'(TAPS - 1)) begin
                            coef_ready_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end
                    end else if (x_valid && x_ready) begin
                        delay_q[wp_q] <= x;
                        acc_q         <= '0;
                        k_q           <= '0;
                        state_q       <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + prod_ext_d;
                    k_q   <= k_q + c_aw'(1);
                    if (k_q == c_last) begin
                        k_q     <= '0;
                        wp_q    <= (wp_q == c_last) ? '0 : wp_q + c_aw'(1);
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    y_q       <= y_d;
                    y_valid_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_tdm_engine
//  Description : Self-checking bench for fir_tdm_engine. Two 4-tap instances
//                share stimulus: one saturating with no shift, one wrapping
//                with a shift of 2. Outputs are compared to a convolution
//                model over the history of accepted samples.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_tdm_engine;

    localparam int TAPS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               ALU_restn = 1'b0;
    logic signed [15:0] b         = '0;
    logic               b_valid   = 1'b0;
    logic               b_first   = 1'b0;
    logic signed [15:0] x         = '0;
    logic               x_valid   = 1'b0;

    logic               coef_ready_a, x_ready_a, y_valid_a, overrun_a;
    logic signed [15:0] y_a;
    logic               coef_ready_b, x_ready_b, y_valid_b, overrun_b;
    logic signed [15:0] y_b;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] mb[TAPS];
    logic signed [15:0] cv[TAPS];
    logic signed [15:0] hist[$];

    fir_tdm_engine #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(0), .SAT_EN(1)) u_sat (
        .clk(clk), .ALU_restn(ALU_restn), .b(b), .b_valid(b_valid), .b_first(b_first),
        .coef_ready(coef_ready_a), .x(x), .x_valid(x_valid), .x_ready(x_ready_a),
        .y(y_a), .y_valid(y_valid_a), .overrun(overrun_a)
    );

    fir_tdm_engine #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(2), .SAT_EN(0)) u_wrap (
        .clk(clk), .ALU_restn(ALU_restn), .b(b), .b_valid(b_valid), .b_first(b_first),
        .coef_ready(coef_ready_b), .x(x), .x_valid(x_valid), .x_ready(x_ready_b),
        .y(y_b), .y_valid(y_valid_b), .overrun(overrun_b)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // y[n] = sum b[k]*x[n-k], samples before the first one count as 0
    function automatic longint ref_y(input int shift, input bit sat);
        longint acc;
        longint r;
        int     n;
        logic [15:0] lo;
        acc = 0;
        n   = hist.size();
        for (int k = 0; k < TAPS; k++) begin
            if (n - 1 - k >= 0) acc += longint'(mb[k]) * longint'(hist[n-1-k]);
        end
        r = acc >>> shift;
        if (sat) begin
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
            return r;
        end
        lo = r[15:0];
        return longint'($signed(lo));
    endfunction

    task automatic do_reset();
        ALU_restn = 1'b0;
        x_valid   = 1'b0;
        b_valid   = 1'b0;
        b_first   = 1'b0;
        tick();
        chk("rst_y_a", y_a, 0);
        chk("rst_y_b", y_b, 0);
        chk("rst_y_valid", y_valid_a, 0);
        chk("rst_coef_ready", coef_ready_a, 0);
        chk("rst_x_ready", x_ready_a, 0);
        chk("rst_overrun", overrun_a, 0);
        ALU_restn = 1'b1;
        hist.delete();
    endtask

    task automatic load_coefs();
        for (int i = 0; i < TAPS; i++) begin
            b_valid = 1'b1;
            b_first = (i == 0);
            b       = cv[i];
            tick();
        end
        b_valid = 1'b0;
        b_first = 1'b0;
        mb      = cv;
        chk("coef_ready", coef_ready_a, 1);
        chk("x_ready_loaded", x_ready_a, 1);
    endtask

    task automatic rand_coefs();
        for (int i = 0; i < TAPS; i++) cv[i] = 16'($urandom());
    endtask

    // One sample through the handshake; optionally pokes x_valid in the
    // second MAC cycle, which must be dropped and flagged.
    task automatic send(input logic signed [15:0] xv, input bit intrude);
        int      cnt;
        bit      seen;
        longint  ea;
        longint  eb;
        cnt = 0;
        while (!x_ready_a && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("x_ready_wait", x_ready_a, 1);
        x       = xv;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        hist.push_back(xv);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            if (intrude && cnt == 1) begin
                x       = 16'sh1234;
                x_valid = 1'b1;
            end
            tick();
            x_valid = 1'b0;
            cnt++;
            if (y_valid_a) seen = 1'b1;
        end
        ea = ref_y(0, 1'b1);
        eb = ref_y(2, 1'b0);
        chk("latency", cnt, TAPS + 1);
        chk("y_sat", y_a, ea);
        chk("y_wrap", y_b, eb);
        chk("y_valid_b", y_valid_b, 1);
        if (intrude) chk("overrun_mac", overrun_a, 1);
        tick();
        chk("y_valid_pulse", y_valid_a, 0);
        chk("y_hold", y_a, ea);
    endtask

    initial begin
        bit pulse;

        // Reset state, then impulse response
        do_reset();
        cv = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        load_coefs();
        send(16'sd1, 1'b0);
        chk("impulse_y0", y_a, 1);
        repeat (4) send(16'sd0, 1'b0);
        chk("impulse_tail", y_a, 0);

        // Step response with pointer wrap
        do_reset();
        cv = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        load_coefs();
        repeat (10) send(16'sd5, 1'b0);
        chk("step_final", y_a, 20);

        // Beats past the end of a load are ignored
        b_valid = 1'b1;
        b       = 16'sh7777;
        tick();
        tick();
        b_valid = 1'b0;
        chk("extra_beats_ready", coef_ready_a, 1);
        send(16'sd5, 1'b0);

        // Restart mid-load: coef_ready waits for a full set
        rand_coefs();
        b_valid = 1'b1;
        b_first = 1'b1;
        b       = 16'sh0bad;
        tick();
        b_first = 1'b0;
        tick();
        chk("partial_not_ready", coef_ready_a, 0);
        for (int i = 0; i < TAPS; i++) begin
            b_first = (i == 0);
            b       = cv[i];
            tick();
            if (i < TAPS - 1) chk("restart_not_ready", coef_ready_a, 0);
        end
        b_valid = 1'b0;
        b_first = 1'b0;
        mb      = cv;
        chk("restart_ready", coef_ready_a, 1);
        repeat (4) send(16'($urandom()), 1'b0);

        // Saturation at both rails
        do_reset();
        cv = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
        load_coefs();
        repeat (6) send(16'sh7FFF, 1'b0);
        chk("sat_pos", y_a, 32767);
        repeat (6) send(-16'sd32768, 1'b0);
        chk("sat_neg", y_a, -32768);

        // Overrun during a sweep
        do_reset();
        rand_coefs();
        load_coefs();
        send(16'($urandom()), 1'b1);
        repeat (5) send(16'($urandom()), 1'b0);
        chk("overrun_sticky", overrun_a, 1);

        // Sample offered before coefficients are ready
        do_reset();
        x       = 16'sd999;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        chk("early_overrun", overrun_a, 1);
        chk("early_not_ready", x_ready_a, 0);
        rand_coefs();
        load_coefs();
        repeat (3) send(16'($urandom()), 1'b0);

        // Restart beat collides with a sample handshake in IDLE
        rand_coefs();
        b_valid = 1'b1;
        b_first = 1'b1;
        b       = cv[0];
        x       = 16'sd77;
        x_valid = 1'b1;
        #1;
        chk("collide_x_ready", x_ready_a, 0);
        tick();
        x_valid = 1'b0;
        b_first = 1'b0;
        chk("collide_overrun", overrun_a, 1);
        chk("collide_coef_ready", coef_ready_a, 0);
        for (int i = 1; i < TAPS; i++) begin
            b = cv[i];
            tick();
        end
        b_valid = 1'b0;
        mb      = cv;
        chk("collide_reload", coef_ready_a, 1);
        repeat (4) send(16'($urandom()), 1'b0);

        // Randomized stream with idle gaps
        do_reset();
        rand_coefs();
        load_coefs();
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(16'($urandom()), 1'b0);
        end
        chk("rand_no_overrun", overrun_a, 0);

        // Reset mid-sweep aborts the output
        x       = 16'sd1000;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        tick();
        tick();
        ALU_restn = 1'b0;
        tick();
        chk("abort_y", y_a, 0);
        chk("abort_y_valid", y_valid_a, 0);
        chk("abort_coef_ready", coef_ready_a, 0);
        ALU_restn = 1'b1;
        pulse     = 1'b0;
        repeat (TAPS + 4) begin
            tick();
            if (y_valid_a || y_valid_b) pulse = 1'b1;
        end
        chk("abort_no_pulse", pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
